tx_unit: RTL

TX_UNIT -- requirements
Module: tx_unit

---
 rtl/tx_unit_pkg.sv | 15 +
 rtl/tx_unit_fifo.sv | 63 ++++++
 rtl/tx_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tx_unit_pkg.sv
// Shared UART definitions: transmitter FSM encoding and bit-timing constants.
package tx_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    BIT_SEND = 2'd2,
    STOP     = 2'd3
  } tx_state_e;

  localparam int OSR_DEFAULT = 8;
  localparam int HALF_BIT    = OSR_DEFAULT / 2;
  localparam int DATA_BITS   = 8;

endpackage

// File: rtl/tx_unit_fifo.sv
// Byte FIFO for the UART transmitter; DEPTH must be a power of two, at least 2.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a push into an empty FIFO
  // cannot be popped in the same cycle and a full FIFO rejects even with a pop.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tx_unit.sv
// UART 8N1 transmitter: FIFO-buffered bytes serialised on en_tx ticks, OSR ticks per bit.
module tx_unit
  import tx_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OSR   = OSR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tx,
  input  logic [7:0] d_in,
  input  logic       we,
  output logic       txd,
  output logic       ts,
  output logic       busy,
  output logic       irq,
  output logic       ovf
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] SAMPLE_MAX = CW'(OSR - 1);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_sample_q, cnt_sample_d;
  logic [2:0]      cnt_bits_q, cnt_bits_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (we),
    .pop   (fifo_pop),
    .din   (d_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign txd  = txd_q;
  assign irq  = irq_q;
  assign ovf  = ovf_q;
  assign ts   = !fifo_full;
  assign busy = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d      = state_q;
    cnt_sample_d = cnt_sample_q;
    cnt_bits_d   = cnt_bits_q;
    shift_d      = shift_q;
    txd_d        = txd_q;
    irq_d        = 1'b0;
    ovf_d        = we && fifo_full;
    fifo_pop     = 1'b0;
    if (en_tx) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            shift_d      = fifo_dout;
            txd_d        = 1'b0;
            cnt_sample_d = SAMPLE_MAX;
            cnt_bits_d   = 3'd7;
            state_d      = START;
          end
        end
        START: begin
          if (cnt_sample_q == '0) begin
            cnt_sample_d = SAMPLE_MAX;
            txd_d        = shift_q[0];
            state_d      = BIT_SEND;
          end else begin
            cnt_sample_d = cnt_sample_q - CW'(1);
          end
        end
        BIT_SEND: begin
          if (cnt_sample_q == '0) begin
            cnt_sample_d = SAMPLE_MAX;
            shift_d      = shift_q >> 1;
            if (cnt_bits_q == 3'd0) begin
              txd_d   = 1'b1;
              state_d = STOP;
            end else begin
              cnt_bits_d = cnt_bits_q - 3'd1;
              txd_d      = shift_q[1];
            end
          end else begin
            cnt_sample_d = cnt_sample_q - CW'(1);
          end
        end
        STOP: begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (cnt_sample_q == '0) begin
            cnt_sample_d = SAMPLE_MAX;
            irq_d        = 1'b1;
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              shift_d    = fifo_dout;
              txd_d      = 1'b0;
              cnt_bits_d = 3'd7;
              state_d    = START;
            end else begin
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_sample_d = cnt_sample_q - CW'(1);
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_sample_q <= '0;
      cnt_bits_q   <= '0;
      shift_q      <= '0;
      txd_q        <= 1'b1;
      irq_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_sample_q <= cnt_sample_d;
      cnt_bits_q   <= cnt_bits_d;
      shift_q      <= shift_d;
      txd_q        <= txd_d;
      irq_q        <= irq_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule
